// File: rtl/team_wb_pkg.sv
// Shared definitions for the team Wishbone manager: bus widths, FSM states
// and the default timeout/error-data values.
package team_wb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam int unsigned DEFAULT_TIMEOUT = 255;
  localparam logic [DAT_W-1:0] DEFAULT_ERR_DATA = 32'hBAD0_BAD0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } wb_state_e;

endpackage

// File: rtl/team_wb_manager.sv
// Wishbone classic manager: turns one valid/ready request into a registered
// single-beat bus cycle, with a timeout so every request gets a response.
module team_wb_manager
  import team_wb_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = DEFAULT_TIMEOUT,
  parameter int unsigned       TO_W     = 8,
  parameter logic [DAT_W-1:0]  ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [DAT_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DAT_W-1:0]  rsp_rdata,
  output logic [ADR_W-1:0]  ADR_O,
  output logic [DAT_W-1:0]  DAT_O,
  output logic [SEL_W-1:0]  SEL_O,
  output logic              WE_O,
  output logic              STB_O,
  output logic              CYC_O,
  input  logic [DAT_W-1:0]  DAT_I,
  input  logic              ACK_I
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  wb_state_e        state, state_next;
  logic [TO_W-1:0]  to_cnt, to_cnt_d;
  logic [ADR_W-1:0] adr_d;
  logic [DAT_W-1:0] dat_d, rdata_d;
  logic [SEL_W-1:0] sel_d;
  logic             we_d, stb_d, cyc_d, rsp_valid_d, rsp_err_d;
  logic             timeout_hit;

  assign timeout_hit = (to_cnt == TO_LAST);
  assign req_ready   = (state == IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid) state_next = BUSY;
      BUSY:    if (ACK_I || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An ack on the threshold cycle is checked first, so it beats the timeout.
  always_comb begin
    adr_d       = ADR_O;
    dat_d       = DAT_O;
    sel_d       = SEL_O;
    we_d        = WE_O;
    stb_d       = STB_O;
    cyc_d       = CYC_O;
    rdata_d     = rsp_rdata;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    to_cnt_d    = to_cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          adr_d    = req_adr;
          dat_d    = req_wdata;
          sel_d    = req_sel;
          we_d     = req_we;
          stb_d    = 1'b1;
          cyc_d    = 1'b1;
          to_cnt_d = '0;
        end
      end
      BUSY: begin
        if (ACK_I) begin
          stb_d       = 1'b0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          if (!WE_O) rdata_d = DAT_I;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
          if (timeout_hit) begin
            stb_d       = 1'b0;
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = ERR_DATA;
          end
        end
      end
      RESP:    ;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      STB_O     <= 1'b0;
      CYC_O     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      to_cnt    <= '0;
    end else begin
      ADR_O     <= adr_d;
      DAT_O     <= dat_d;
      SEL_O     <= sel_d;
      WE_O      <= we_d;
      STB_O     <= stb_d;
      CYC_O     <= cyc_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rdata_d;
      to_cnt    <= to_cnt_d;
    end
  end

endmodule
